// File: rtl/e_md_sched.sv
// e_md_sched: E-stage multiply/divide scheduler holding HI/LO behind a fixed-latency busy countdown.
module e_md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  op_E,
  input  logic [31:0] src_a_E,
  input  logic [31:0] src_b_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  state_e      state;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        wr_q, wr_d;
  logic        accept, sgn_m, sgn_d;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, div_b, q, r, quo, rem;
  always_comb begin
    state  = (cnt_q != 4'd0) ? RUN : IDLE;
    accept = start_E & (state == IDLE) & (op_E <= OP_MTLO);
    sgn_m  = (op_E == OP_MULT);
    prod   = {{32{sgn_m & src_a_E[31]}}, src_a_E} * {{32{sgn_m & src_b_E[31]}}, src_b_E};
    // one unsigned divider on magnitudes; signs restored for div afterwards
    sgn_d  = (op_E == OP_DIV);
    mag_a  = (sgn_d & src_a_E[31]) ? -src_a_E : src_a_E;
    mag_b  = (sgn_d & src_b_E[31]) ? -src_b_E : src_b_E;
    div_b  = (src_b_E == 32'd0) ? 32'd1 : mag_b;
    q      = mag_a / div_b;
    r      = mag_a % div_b;
    quo    = (sgn_d & (src_a_E[31] ^ src_b_E[31])) ? -q : q;
    rem    = (sgn_d & src_a_E[31]) ? -r : r;
    cnt_d    = (state == RUN) ? cnt_q - 4'd1 : cnt_q;
    hi_d     = (cnt_q == 4'd1 && wr_q) ? res_hi_q : hi_q;
    lo_d     = (cnt_q == 4'd1 && wr_q) ? res_lo_q : lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    if (accept) begin
      case (op_E)
        OP_MULT, OP_MULTU: begin
          {res_hi_d, res_lo_d} = prod;
          wr_d  = 1'b1;
          cnt_d = 4'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          res_hi_d = rem;
          res_lo_d = quo;
          wr_d     = (src_b_E != 32'd0);
          cnt_d    = 4'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = src_a_E;
        default: lo_d = src_a_E;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end
  assign busy     = (state == RUN);
  assign stall_md = md_use_D & (start_E | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;
  // the hazard unit must never present a new MDU op while one is running
  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(start_E && busy));
endmodule

// File: tb/tb_e_md_sched.sv
// tb_e_md_sched: directed literal checks plus randomized traffic compared every cycle to a timestamp model.
module tb_e_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 0, reset = 1, start_E = 0, md_use_D = 0;
  logic [2:0]  op_E = 0;
  logic [31:0] src_a_E = 0, src_b_E = 0;
  logic        busy, stall_md;
  logic [31:0] hi, lo;
  int n_tests = 0, n_fail = 0;

  e_md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start_E(start_E), .op_E(op_E), .src_a_E(src_a_E),
    .src_b_E(src_b_E), .md_use_D(md_use_D), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // model: the pending op is remembered by its accept cycle and latency
  int          cyc = 0, acc = -1, n = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0, c_h, c_l;
  bit          p_wr = 0, c_wr, b_now;
  int          c_lat;

  function automatic bit m_busy(input int c);
    return acc >= 0 && c > acc && c <= acc + n;
  endfunction

  task automatic compute(input logic [2:0] op, input logic [31:0] a, b,
                         output logic [31:0] h, l, output bit wr, output int lat);
    longint sa, sb, r64;
    longint unsigned ua, ub, u64;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    h = 0; l = 0; wr = 1; lat = MC;
    case (op)
      3'd0: begin r64 = sa * sb; {h, l} = r64; end
      3'd1: begin u64 = ua * ub; {h, l} = u64; end
      3'd2: begin lat = DC; if (b == 0) wr = 0; else begin l = 32'(sa / sb); h = 32'(sa % sb); end end
      3'd3: begin lat = DC; if (b == 0) wr = 0; else begin l = 32'(ua / ub); h = 32'(ua % ub); end end
      default: lat = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_hi = 0; m_lo = 0; acc = -1;
    end else begin
      b_now = m_busy(cyc);
      if (acc >= 0 && cyc == acc + n) begin
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        acc = -1;
      end
      if (start_E && !b_now && op_E <= 3'd5) begin
        compute(op_E, src_a_E, src_b_E, c_h, c_l, c_wr, c_lat);
        if (op_E == 3'd4) m_hi = src_a_E;
        else if (op_E == 3'd5) m_lo = src_a_E;
        else begin acc = cyc; n = c_lat; p_hi = c_h; p_lo = c_l; p_wr = c_wr; end
      end
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("cmp_busy", 32'(busy), 32'(m_busy(cyc)));
    chk("cmp_stall", 32'(stall_md), 32'(md_use_D & (start_E | m_busy(cyc))));
    chk("cmp_hi", hi, m_hi);
    chk("cmp_lo", lo, m_lo);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b);
    start_E = 1; op_E = op; src_a_E = a; src_b_E = b;
    tick();
    start_E = 0; op_E = 3'($urandom); src_a_E = $urandom; src_b_E = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1 chk("rst_busy", 32'(busy), 0); chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    md_use_D = 1; start_E = 1; op_E = 0; src_a_E = 32'hFFFFFFFE; src_b_E = 3;
    #1 chk("mult_stall_c0", 32'(stall_md), 1);
    tick();
    start_E = 0; src_a_E = $urandom; src_b_E = $urandom;
    for (int i = 1; i <= MC; i++) begin
      #1 chk("mult_busy", 32'(busy), 1); chk("mult_stall", 32'(stall_md), 1);
      tick();
    end
    #1 chk("mult_done_busy", 32'(busy), 0); chk("mult_done_stall", 32'(stall_md), 0);
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFA);
    md_use_D = 0;
    issue(1, 32'hFFFFFFFE, 3);
    for (int i = 1; i <= MC; i++) begin
      #1 chk("multu_busy", 32'(busy), 1); chk("multu_nostall", 32'(stall_md), 0);
      tick();
    end
    #1 chk("multu_hi", hi, 32'h2); chk("multu_lo", lo, 32'hFFFFFFFA);
    issue(2, 32'hFFFFFFF9, 2);
    repeat (DC - 1) tick();
    #1 chk("div_busy_last", 32'(busy), 1);
    tick();
    #1 chk("div_busy_end", 32'(busy), 0); chk("div_hi", hi, 32'hFFFFFFFF); chk("div_lo", lo, 32'hFFFFFFFD);
    issue(3, 7, 2);
    repeat (DC) tick();
    #1 chk("divu_hi", hi, 1); chk("divu_lo", lo, 3);
    issue(4, 32'hDEADBEEF, 0);
    #1 chk("mthi_hi", hi, 32'hDEADBEEF); chk("mthi_lo", lo, 3); chk("mthi_busy", 32'(busy), 0);
    issue(5, 32'h12345678, 0);
    #1 chk("mtlo_lo", lo, 32'h12345678); chk("mtlo_busy", 32'(busy), 0);
    issue(4, 32'h11, 0);
    issue(5, 32'h22, 0);
    issue(2, 5, 0);
    #1 chk("dbz_busy", 32'(busy), 1);
    repeat (DC) tick();
    #1 chk("dbz_idle", 32'(busy), 0); chk("dbz_hi", hi, 32'h11); chk("dbz_lo", lo, 32'h22);
    issue(3, 9, 0);
    repeat (DC) tick();
    #1 chk("dbzu_hi", hi, 32'h11); chk("dbzu_lo", lo, 32'h22);
    issue(2, 32'h80000000, 32'hFFFFFFFF);
    repeat (DC) tick();
    #1 chk("ovf_hi", hi, 0); chk("ovf_lo", lo, 32'h80000000);
    issue(2, 100, 7);
    repeat (3) tick();
    #2 reset = 1;
    #1 chk("arst_busy", 32'(busy), 0); chk("arst_hi", hi, 0); chk("arst_lo", lo, 0);
    reset = 0;
    repeat (8) tick();
    #1 chk("post_rst_hi", hi, 0); chk("post_rst_lo", lo, 0);
    issue(0, 6, 7);
    repeat (MC) tick();
    #1 chk("post_rst_mult_lo", lo, 42); chk("post_rst_mult_hi", hi, 0);
    for (int k = 0; k < 600; k++) begin
      md_use_D = 1'($urandom);
      if (!m_busy(cyc) && $urandom_range(0, 2) != 0) begin
        start_E = 1; op_E = 3'($urandom_range(0, 7)); src_a_E = pick(); src_b_E = pick();
      end else begin
        start_E = 0; src_a_E = $urandom; src_b_E = $urandom;
      end
      tick();
    end
    start_E = 0; md_use_D = 0;
    repeat (DC + 2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
